// File: rtl/segment7_if.sv
// Display bus for segment7: operand/result inputs plus active-low anode and cathode outputs of the three digit groups.
interface segment7_if;
  logic [3:0] data1;
  logic [3:0] data2;
  logic [7:0] data3;
  logic [1:0] Anode_Activate1;
  logic [1:0] Anode_Activate2;
  logic [3:0] Anode_Activate3;
  logic [6:0] LED_OUT1;
  logic [6:0] LED_OUT2;
  logic [6:0] LED_OUT3;

  modport master (
    output data1, data2, data3,
    input  Anode_Activate1, Anode_Activate2, Anode_Activate3,
    input  LED_OUT1, LED_OUT2, LED_OUT3
  );

  modport slave (
    input  data1, data2, data3,
    output Anode_Activate1, Anode_Activate2, Anode_Activate3,
    output LED_OUT1, LED_OUT2, LED_OUT3
  );
endinterface

// File: rtl/segment7.sv
// Triple multiplexed 7-segment driver (2 + 2 + 4 decimal digits) sharing one refresh counter.
// Optional LEADING_ZERO_BLANK_EN macro blanks leading zero digits.
module segment7 #(
  parameter int unsigned REFRESH_BITS = 20
) (
  input logic      clk,
  input logic      reset,
  segment7_if.slave disp
);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LZB = 1'b1;
`else
  localparam logic LZB = 1'b0;
`endif

  logic [REFRESH_BITS-1:0] count_q;
  logic [1:0]              sel;

  logic [3:0] d1_tens, d1_ones, d2_tens, d2_ones;
  logic [3:0] d3_hund, d3_tens, d3_ones;

  logic [1:0] an1_d, an1_q, an2_d, an2_q;
  logic [3:0] an3_d, an3_q;
  logic [6:0] led1_d, led1_q, led2_d, led2_q, led3_d, led3_q;

  function automatic logic [6:0] seg_enc(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = '1;
    endcase
    return blank ? '1 : s;
  endfunction

  // Counter depends only on itself so unknown data inputs cannot disturb the scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_q + 1'b1;
  end

  assign sel = count_q[REFRESH_BITS-1 -: 2];

  // Groups 1/2 are 0..15, so tens is a single compare against 10.
  assign d1_tens = (disp.data1 >= 4'd10) ? 4'd1 : 4'd0;
  assign d1_ones = (disp.data1 >= 4'd10) ? disp.data1 - 4'd10 : disp.data1;
  assign d2_tens = (disp.data2 >= 4'd10) ? 4'd1 : 4'd0;
  assign d2_ones = (disp.data2 >= 4'd10) ? disp.data2 - 4'd10 : disp.data2;

  assign d3_hund = 4'(disp.data3 / 8'd100);
  assign d3_tens = 4'((disp.data3 / 8'd10) % 8'd10);
  assign d3_ones = 4'(disp.data3 % 8'd10);

  always_comb begin
    an1_d  = '1;
    an2_d  = '1;
    an3_d  = '1;
    led1_d = '1;
    led2_d = '1;
    led3_d = '1;

    if (!sel[1]) begin
      an1_d  = 2'b01;
      an2_d  = 2'b01;
      led1_d = seg_enc(d1_tens, LZB && (d1_tens == 4'd0));
      led2_d = seg_enc(d2_tens, LZB && (d2_tens == 4'd0));
    end else begin
      an1_d  = 2'b10;
      an2_d  = 2'b10;
      led1_d = seg_enc(d1_ones, 1'b0);
      led2_d = seg_enc(d2_ones, 1'b0);
    end

    case (sel)
      2'd0: begin
        an3_d  = 4'b0111;
        led3_d = seg_enc(4'd0, LZB);
      end
      2'd1: begin
        an3_d  = 4'b1011;
        led3_d = seg_enc(d3_hund, LZB && (d3_hund == 4'd0));
      end
      2'd2: begin
        an3_d  = 4'b1101;
        led3_d = seg_enc(d3_tens, LZB && (d3_hund == 4'd0) && (d3_tens == 4'd0));
      end
      default: begin
        an3_d  = 4'b1110;
        led3_d = seg_enc(d3_ones, 1'b0);
      end
    endcase
  end

  // Anodes and cathodes share one register stage so they always switch together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an1_q  <= '1;
      an2_q  <= '1;
      an3_q  <= '1;
      led1_q <= '1;
      led2_q <= '1;
      led3_q <= '1;
    end else begin
      an1_q  <= an1_d;
      an2_q  <= an2_d;
      an3_q  <= an3_d;
      led1_q <= led1_d;
      led2_q <= led2_d;
      led3_q <= led3_d;
    end
  end

  assign disp.Anode_Activate1 = an1_q;
  assign disp.Anode_Activate2 = an2_q;
  assign disp.Anode_Activate3 = an3_q;
  assign disp.LED_OUT1        = led1_q;
  assign disp.LED_OUT2        = led2_q;
  assign disp.LED_OUT3        = led3_q;

endmodule

// File: tb/tb_segment7.sv
// Directed table-driven bench for segment7 with REFRESH_BITS=4; expectations follow LEADING_ZERO_BLANK_EN.
module tb_segment7;
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S7 = 7'b0001111, S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z = SB;
`else
  localparam logic [6:0] Z = S0;
`endif

  typedef struct {
    logic [3:0] d1;
    logic [3:0] d2;
    logic [7:0] d3;
    logic [1:0] sel;
    logic [1:0] an1;
    logic [6:0] l1;
    logic [1:0] an2;
    logic [6:0] l2;
    logic [3:0] an3;
    logic [6:0] l3;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  segment7_if disp ();

  segment7 #(.REFRESH_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .disp  (disp)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [3:0] cnt = '0;
  logic [1:0] reg_sel = '0;
  vec_t vecs[$];
  logic [3:0] an3_tab [4];

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    reg_sel = cnt[3:2];
    cnt = cnt + 4'd1;
    #1;
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_an1"}, {5'd0, disp.Anode_Activate1}, 7'b0000011);
    chk({tag, "_an2"}, {5'd0, disp.Anode_Activate2}, 7'b0000011);
    chk({tag, "_an3"}, {3'd0, disp.Anode_Activate3}, 7'b0001111);
    chk({tag, "_led1"}, disp.LED_OUT1, SB);
    chk({tag, "_led2"}, disp.LED_OUT2, SB);
    chk({tag, "_led3"}, disp.LED_OUT3, SB);
  endtask

  function automatic void add(input logic [3:0] d1, input logic [3:0] d2, input logic [7:0] d3,
                              input logic [1:0] sel, input logic [1:0] a1, input logic [6:0] l1,
                              input logic [1:0] a2, input logic [6:0] l2, input logic [3:0] a3,
                              input logic [6:0] l3);
    vec_t v;
    v.d1 = d1; v.d2 = d2; v.d3 = d3; v.sel = sel;
    v.an1 = a1; v.l1 = l1; v.an2 = a2; v.l2 = l2; v.an3 = a3; v.l3 = l3;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    an3_tab[0] = 4'b0111; an3_tab[1] = 4'b1011; an3_tab[2] = 4'b1101; an3_tab[3] = 4'b1110;

    add(4'd13, 4'd10, 8'd145, 2'd0, 2'b01, S1, 2'b01, S1, 4'b0111, Z);
    add(4'd13, 4'd10, 8'd145, 2'd1, 2'b01, S1, 2'b01, S1, 4'b1011, S1);
    add(4'd13, 4'd10, 8'd145, 2'd2, 2'b10, S3, 2'b10, S0, 4'b1101, S4);
    add(4'd13, 4'd10, 8'd145, 2'd3, 2'b10, S3, 2'b10, S0, 4'b1110, S5);
    add(4'd15, 4'd0,  8'd255, 2'd0, 2'b01, S1, 2'b01, Z,  4'b0111, Z);
    add(4'd15, 4'd0,  8'd255, 2'd1, 2'b01, S1, 2'b01, Z,  4'b1011, S2);
    add(4'd15, 4'd0,  8'd255, 2'd2, 2'b10, S5, 2'b10, S0, 4'b1101, S5);
    add(4'd15, 4'd0,  8'd255, 2'd3, 2'b10, S5, 2'b10, S0, 4'b1110, S5);
    add(4'd0,  4'd9,  8'd0,   2'd0, 2'b01, Z,  2'b01, Z,  4'b0111, Z);
    add(4'd0,  4'd9,  8'd0,   2'd1, 2'b01, Z,  2'b01, Z,  4'b1011, Z);
    add(4'd0,  4'd9,  8'd0,   2'd2, 2'b10, S0, 2'b10, S9, 4'b1101, Z);
    add(4'd0,  4'd9,  8'd0,   2'd3, 2'b10, S0, 2'b10, S9, 4'b1110, S0);
    add(4'd9,  4'd11, 8'd50,  2'd1, 2'b01, Z,  2'b01, S1, 4'b1011, Z);
    add(4'd9,  4'd11, 8'd50,  2'd2, 2'b10, S9, 2'b10, S1, 4'b1101, S5);
    add(4'd10, 4'd5,  8'd107, 2'd0, 2'b01, S1, 2'b01, Z,  4'b0111, Z);
    add(4'd10, 4'd5,  8'd107, 2'd2, 2'b10, S0, 2'b10, S5, 4'b1101, S0);
    add(4'd10, 4'd5,  8'd107, 2'd3, 2'b10, S0, 2'b10, S5, 4'b1110, S7);

    disp.data1 = '0; disp.data2 = '0; disp.data3 = '0;
    #100;
    chk_blank("reset");
    #100;
    @(negedge clk);
    reset = 1'b0;
    cnt = '0;
    step();
    chk("first_slot_an3", {3'd0, disp.Anode_Activate3}, 7'b0000111);
    chk("first_slot_led3", disp.LED_OUT3, Z);

    foreach (vecs[i]) begin
      int unsigned guard;
      disp.data1 = vecs[i].d1;
      disp.data2 = vecs[i].d2;
      disp.data3 = vecs[i].d3;
      step();
      guard = 0;
      while (reg_sel != vecs[i].sel && guard < 16) begin
        step();
        guard++;
      end
      if (guard >= 16) begin
        compared++;
        mismatched++;
        $display("FAIL slot_wait[%0d]: got timeout expected sel %0d", i, vecs[i].sel);
      end else begin
        chk($sformatf("v%0d_an1", i), {5'd0, disp.Anode_Activate1}, {5'd0, vecs[i].an1});
        chk($sformatf("v%0d_led1", i), disp.LED_OUT1, vecs[i].l1);
        chk($sformatf("v%0d_an2", i), {5'd0, disp.Anode_Activate2}, {5'd0, vecs[i].an2});
        chk($sformatf("v%0d_led2", i), disp.LED_OUT2, vecs[i].l2);
        chk($sformatf("v%0d_an3", i), {3'd0, disp.Anode_Activate3}, {3'd0, vecs[i].an3});
        chk($sformatf("v%0d_led3", i), disp.LED_OUT3, vecs[i].l3);
      end
    end

    // Wrap: unknown data must not disturb the anode scan over a full wrap plus four.
    disp.data1 = 'x; disp.data2 = 'x; disp.data3 = 'x;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("wrap%0d_an3", k), {3'd0, disp.Anode_Activate3}, {3'd0, an3_tab[reg_sel]});
    end

    // Mid-scan reset at sel=2 must blank outputs without waiting for a clock edge.
    disp.data1 = 4'd13; disp.data2 = 4'd10; disp.data3 = 8'd145;
    begin
      int unsigned guard;
      guard = 0;
      step();
      while (reg_sel != 2'd2 && guard < 16) begin
        step();
        guard++;
      end
      chk("pre_reset_an3", {3'd0, disp.Anode_Activate3}, 7'b0001101);
    end
    #2;
    reset = 1'b1;
    #1;
    chk_blank("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt = '0;
    step();
    chk("restart_an3", {3'd0, disp.Anode_Activate3}, 7'b0000111);
    chk("restart_led3", disp.LED_OUT3, Z);
    chk("restart_an1", {5'd0, disp.Anode_Activate1}, 7'b0000001);
    chk("restart_led1", disp.LED_OUT1, S1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/segment7.md
Name: segment7

Overview:
- Triple multiplexed 7-segment display driver with one time-multiplexed refresh counter.
- Group 1 shows data1 (0–15) as 2 decimal digits; group 2 shows data2 as 2 decimal digits; group 3 shows data3 (0–255) as 4 decimal digits.
- Sits between arithmetic/operand logic and board-level anode/cathode pins.
- Anodes and cathodes are active-low.

Parameters:
- REFRESH_BITS, 20, width of the free-running refresh counter. Its top 2 bits select the digit. Sim benches use 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data1  input  4  operand 1, unsigned.
- data2  input  4  operand 2, unsigned.
- data3  input  8  result, unsigned.
- Anode_Activate1  output  2  group-1 digit enables, active-low; bit1 = tens, bit0 = ones.
- Anode_Activate2  output  2  group-2 digit enables, same encoding as group 1.
- Anode_Activate3  output  4  group-3 digit enables, active-low; bit3 = thousands … bit0 = ones.
- LED_OUT1  output  7  group-1 cathodes, active-low, order {a,b,c,d,e,f,g} (a = bit6).
- LED_OUT2  output  7  group-2 cathodes, same order.
- LED_OUT3  output  7  group-3 cathodes, same order.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous, active-high.
  - In reset: refresh counter = 0; all anode outputs all-ones (all digits off); all LED_OUT = 7'b1111111.
- Refresh counter:
  - Increments by 1 every clk edge and wraps modulo 2^REFRESH_BITS.
  - sel = counter[REFRESH_BITS-1 : REFRESH_BITS-2].
- Group 3 digit select (uses sel):
  - sel 0: anode 4'b0111, thousands digit.
  - sel 1: anode 4'b1011, hundreds digit.
  - sel 2: anode 4'b1101, tens digit.
  - sel 3: anode 4'b1110, ones digit.
- Groups 1 and 2 digit select (use sel[1] only):
  - sel[1]=0: anode 2'b01, tens digit.
  - sel[1]=1: anode 2'b10, ones digit.
- Binary-to-decimal conversion, pure combinational:
  - Groups 1/2: tens = data/10 (0 or 1); ones = data%10.
  - Group 3: hundreds = data3/100; tens = (data3/10)%10; ones = data3%10; thousands is always 0.
  - Divide/modulo or double-dabble are both acceptable; results must be exact for every input value.
- Segment encoding (active-low, abcdefg):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100.
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100.
  - Any other value = 1111111.
- Output timing:
  - Anode and LED_OUT outputs are registered: one clk of latency from counter/data to pins.
  - Anode and segment always update in the same cycle, so there is no ghosting.
  - Data changes take effect on the next displayed slot after a 1-cycle register delay. Inputs are not latched.
- Boundaries:
  - data1/data2 = 15 gives "15"; = 0 gives "00".
  - data3 = 255 gives "0255"; = 0 gives "0000".
  - X/unknown inputs must not corrupt the counter.
  - Reset asserted mid-scan immediately blanks all outputs. After release, scanning restarts at sel = 0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Leading zero digits output 7'b1111111 while their anode is still driven normally.
  - Group 1/2: tens is blanked when 0.
  - Group 3: thousands is always blanked; hundreds is blanked if 0; tens is blanked if hundreds and tens are both 0.
  - The ones digit is never blanked, so value 0 shows a single "0".
- Undefined: all digits are shown, including leading zeros, as above.

Test Plan:
- Reset: hold reset for 200 ns with REFRESH_BITS=4 -> all anodes all-ones and all LED_OUT 1111111. After release, the first registered slot shows Anode_Activate3 = 0111.
- data1=13 -> in the sel[1]=0 slot, Anode_Activate1=01 and LED_OUT1=1001111 ("1"). In the sel[1]=1 slot, Anode_Activate1=10 and LED_OUT1=0000110 ("3").
- data2=10 -> tens slot LED_OUT2=1001111; ones slot LED_OUT2=0000001.
- data3=145 -> over 4 sel slots, (Anode_Activate3, LED_OUT3) = (0111, 0000001), (1011, 1001111), (1101, 1001100), (1110, 0100100).
- Extremes: data1=15, data2=0, data3=255 -> "15", "00", "0255". With LEADING_ZERO_BLANK_EN, the thousands slot and data2's tens slot show 1111111.
- Wrap: run 2^REFRESH_BITS+4 clocks -> sel sequence repeats 0,1,2,3 without skipping. Assert reset at sel=2 -> outputs blank asynchronously.
